// File: rtl/fp_mult_result_stage.sv
// fp_mult_result_stage: FIFO-buffered, IEEE-754-classified output stage for the FP multiplier
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_result/in_overflow/in_underflow : multiplier result handshake
//   out_valid/out_ready/out_result/out_overflow/out_underflow/out_class/out_sign : head entry
//   flag_clear : clears sticky flags and op_count (a same-cycle push wins)
//   sticky_overflow/sticky_underflow/sticky_invalid/op_count : status readout
module fp_mult_result_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic [2:0]       out_class,
    output logic             out_sign,
    input  logic             flag_clear,
    output logic             sticky_overflow,
    output logic             sticky_underflow,
    output logic             sticky_invalid,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      r_result [DEPTH];
    logic             r_ovf [DEPTH];
    logic             r_unf [DEPTH];
    logic [2:0]       r_class [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             r_sov;
    logic             r_sun;
    logic             r_sinv;
    logic [CNT_W-1:0] r_op_count;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_exp;
    logic [22:0]      w_man;
    logic [2:0]       w_class;
    logic             w_nan;
    logic [CNT_W-1:0] w_cnt_base;

    assign w_exp = in_result[30:23];
    assign w_man = in_result[22:0];

    always_comb begin
        w_class = (w_exp == 8'h00) ? ((w_man == '0) ? 3'd0 : 3'd1) :
                  (w_exp != 8'hFF) ? 3'd2 :
                  (w_man == '0)    ? 3'd3 :
                  w_man[22]        ? 3'd4 : 3'd5;
        w_nan      = (w_class == 3'd4) || (w_class == 3'd5);
        w_cnt_base = flag_clear ? '0 : r_op_count;
    end

    // in_ready looks only at registered occupancy so a full FIFO never chains to out_ready
    assign in_ready  = !rst && (r_count < FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_result    = r_result[r_rd];
    assign out_overflow  = r_ovf[r_rd];
    assign out_underflow = r_unf[r_rd];
    assign out_class     = r_class[r_rd];
    assign out_sign      = r_result[r_rd][31];

    assign sticky_overflow  = r_sov;
    assign sticky_underflow = r_sun;
    assign sticky_invalid   = r_sinv;
    assign op_count         = r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_result[i] <= '0;
                r_ovf[i]    <= 1'b0;
                r_unf[i]    <= 1'b0;
                r_class[i]  <= 3'd0;
            end
        end else begin
            if (w_push) begin
                r_result[r_wr] <= in_result;
                r_ovf[r_wr]    <= in_overflow;
                r_unf[r_wr]    <= in_underflow;
                r_class[r_wr]  <= w_class;
                r_wr           <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // A push in the same cycle as flag_clear restarts the flags from the pushed entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sov      <= 1'b0;
            r_sun      <= 1'b0;
            r_sinv     <= 1'b0;
            r_op_count <= '0;
        end else if (w_push) begin
            r_sov      <= (r_sov  && !flag_clear) || in_overflow;
            r_sun      <= (r_sun  && !flag_clear) || in_underflow;
            r_sinv     <= (r_sinv && !flag_clear) || w_nan;
            r_op_count <= w_cnt_base + CNT_W'(w_cnt_base != CNT_MAX);
        end else if (flag_clear) begin
            r_sov      <= 1'b0;
            r_sun      <= 1'b0;
            r_sinv     <= 1'b0;
            r_op_count <= '0;
        end
    end
endmodule

// File: doc/fp_mult_result_stage.md
Name: fp_mult_result_stage

Overview:
Registered output stage that sits directly downstream of the combinational single-precision multiplier. It accepts the multiplier's result word and overflow/underflow flags through a valid/ready handshake and buffers them in a small FIFO. It classifies each result per IEEE-754 and presents it to the consumer with a valid/ready handshake. It also keeps sticky exception flags and an operation counter for software/status readout.

Parameters:
DEPTH, 4, number of buffered result entries; power of two, >= 2.
CNT_W, 16, width of the accepted-operation counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  multiplier result valid.
in_ready  output  1  stage can accept an entry this cycle.
in_result  input  32  IEEE-754 single result from the multiplier.
in_overflow  input  1  multiplier overflow flag for in_result.
in_underflow  input  1  multiplier underflow flag for in_result.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts the head entry.
out_result  output  32  head entry result word.
out_overflow  output  1  head entry overflow flag.
out_underflow  output  1  head entry underflow flag.
out_class  output  3  head entry class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN.
out_sign  output  1  head entry sign bit (bit 31).
flag_clear  input  1  synchronous clear of the sticky flags and op_count.
sticky_overflow  output  1  set if any accepted entry had overflow.
sticky_underflow  output  1  set if any accepted entry had underflow.
sticky_invalid  output  1  set if any accepted entry was NaN (class 4 or 5).
op_count  output  CNT_W  number of accepted entries; saturating.

Behaviour:
- Reset (async, rst high): occupancy 0, read/write pointers 0, all storage 0, out_valid 0, out_result 0, out_overflow/out_underflow/out_sign 0, out_class 0, all sticky flags 0, op_count 0. in_ready is 0 while rst is high and 1 in the first cycle after release.
- Reset mid-operation: all buffered entries are discarded. Nothing is replayed.
- Push: occurs when in_valid && in_ready. Stores {in_result, in_overflow, in_underflow, class(in_result)} at the write pointer. The write pointer increments mod DEPTH.
- Pop: occurs when out_valid && out_ready. The read pointer increments mod DEPTH.
- in_ready = (occupancy < DEPTH). It depends only on registered state, never on out_ready. When the FIFO is full, in_ready is 0 even if a pop happens in the same cycle.
- out_valid = (occupancy != 0). out_* outputs are driven from the head entry's registers.
- Latency: an entry pushed into an empty FIFO appears on out_* with out_valid=1 in the next cycle.
- Occupancy update: push only +1; pop only -1; push and pop in the same cycle leave it unchanged.
- Ordering: strict FIFO order. out_* stay stable while out_valid && !out_ready.
- Classification, with e = bits 30:23 and m = bits 22:0:
  - e==0, m==0 -> zero (0).
  - e==0, m!=0 -> subnormal (1).
  - e==255, m==0 -> inf (3).
  - e==255, m[22]==1 -> qNaN (4).
  - e==255, m[22]==0, m!=0 -> sNaN (5).
  - otherwise -> normal (2).
- Sticky flags update on push only:
  - sticky_overflow |= in_overflow.
  - sticky_underflow |= in_underflow.
  - sticky_invalid |= (class is 4 or 5).
- op_count: +1 on each push, saturating at 2^CNT_W-1.
- flag_clear: next cycle all sticky flags and op_count are 0. If a push happens in the same cycle, the push wins: each flag takes the pushed entry's value and op_count becomes 1.
- in_* values are ignored when in_valid is 0. out_* values are don't-care when out_valid is 0, but they hold the last head entry (no X).

Test Plan:
- Single entry: push 0x40000000 (2.0 = 2*1), out_ready=1 -> next cycle out_valid=1, out_result=0x40000000, out_class=2, out_sign=0, op_count=1; following cycle out_valid=0.
- Classification: push 0x00000000, 0x00400000, 0xFF800000 with overflow=1, 0x7FC00000, 0x7F800001 -> out_class 0,1,3,4,5 in order. Afterwards sticky_overflow=1 and sticky_invalid=1; out_sign=1 only for the third entry.
- Full/backpressure: out_ready=0, push 4 entries (0x40800000, 0x41280000, 0xC0000000, 0x410C0000) -> in_ready=0 after the 4th push. A 5th in_valid is not accepted. Raising out_ready drains the entries in order, and in_ready returns to 1 after the first pop.
- Simultaneous push/pop at occupancy 2 for 8 cycles with pointer wrap -> occupancy stays 2, no loss or reordering, op_count counts every push.
- flag_clear with push of 0x00000000 with underflow=1 in the same cycle -> next cycle sticky_underflow=1, sticky_overflow=0, sticky_invalid=0, op_count=1.
- Assert rst for one cycle with 3 entries buffered -> out_valid=0, op_count=0, all stickies 0 immediately. in_ready is 1 after release, and the next push appears at the output alone.
